bcd_serial_adder: RTL

Parametrised multi-digit packed-BCD adder/subtractor. It processes one decimal digit per clock, least-significant digit first, using a start/done handshake. It is the sequential successor to the single-digit combinational BCD adder: it generalises width to DIGITS decimal digits and adds a subtract mode and invalid-digit detection. It sits between operand registers and display/result logic in the lab datapath.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_digit_add.sv | 25 ++
 rtl/bcd_serial_adder.sv | 103 ++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder/subtractor.
package bcd_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t BCD_NINE = 4'd9;
    localparam digit_t BCD_ADJ  = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single decimal digit adder: binary sum plus decimal adjust when above nine.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  digit_t x,
    input  digit_t y,
    input  logic   ci,
    output digit_t d,
    output logic   co
);

    logic [4:0] t;

    always_comb begin
        t = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
        if (t > {1'b0, BCD_NINE}) begin
            d  = t[3:0] + BCD_ADJ;
            co = 1'b1;
        end else begin
            d  = t[3:0];
            co = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder/subtractor, one digit per clock, LSD first.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                busy,
    output logic                done,
    output logic                err,
    output state_t              dbg_state
);

    // Handshake: start is taken only in IDLE (busy=0); busy stays high from the
    // accept edge through the single done cycle; sum/cout/err are valid from done
    // onward and held until the next accepted start.

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    state_t              state, next_state;
    logic [4*DIGITS-1:0] a_q, b_q, b_eff;
    logic                carry, any_bad, accept, last_digit;
    logic [IW-1:0]       idx;
    digit_t              x, y, d;
    logic                co;

    assign accept     = (state == IDLE) && start;
    assign last_digit = (idx == LAST);
    assign x          = a_q[{idx, 2'b00} +: 4];
    assign y          = b_q[{idx, 2'b00} +: 4];
    assign dbg_state  = state;

    bcd_digit_add u_digit (
        .x  (x),
        .y  (y),
        .ci (carry),
        .d  (d),
        .co (co)
    );

    // Subtraction adds the 9's complement of b with a forced carry-in of one.
    always_comb begin
        b_eff   = '0;
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            b_eff[4*i +: 4] = sub ? (BCD_NINE - b[4*i +: 4]) : b[4*i +: 4];
            any_bad = any_bad || (a[4*i +: 4] > BCD_NINE) || (b[4*i +: 4] > BCD_NINE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ADD;
            ADD:     if (last_digit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b_eff;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
            err   <= any_bad;
        end else if (state == ADD) begin
            sum[{idx, 2'b00} +: 4] <= d;
            carry <= co;
            idx   <= last_digit ? '0 : idx + 1'b1;
            if (last_digit) cout <= co;
        end
    end

endmodule
